// File: rtl/axis_pkg.sv
// Shared helpers for the AXIS keep packer: width legality, popcount and keep-mask generation.
package axis_pkg;
  localparam int MAX_BYTES = 16;

  typedef enum logic {PK_FILL, PK_FLUSH} pk_state_e;

  function automatic bit legal_width(input int w);
    return (w == 16) || (w == 32) || (w == 64) || (w == 128);
  endfunction

  function automatic logic [4:0] popcount(input logic [MAX_BYTES-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_BYTES; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  // Contiguous keep from lane 0: n ones.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input logic [4:0] n);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) m[i] = (5'(i) < n);
    return m;
  endfunction
endpackage

// File: rtl/axis_keep_compact.sv
// Combinational lane compactor: squeezes kept bytes down to lane 0 and reports how many there are.
module axis_keep_compact
  import axis_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic [BYTES*8-1:0] data,
  input  logic [BYTES-1:0]   keep,
  output logic [BYTES*8-1:0] cdata,
  output logic [4:0]         cnt
);
  always_comb begin
    logic [4:0] idx;
    cdata = '0;
    idx   = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (keep[i]) begin
        cdata[idx*8 +: 8] = data[i*8 +: 8];
        idx = idx + 5'd1;
      end
    end
  end

  assign cnt = popcount(MAX_BYTES'(keep));
endmodule

// File: rtl/axis_keep_packer.sv
// Packs a sparse (TKEEP-holed) AXI stream into dense beats, one packet per flush, with byte count.
module axis_keep_packer
  import axis_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_PKT_LEN_WIDTH    = 16
) (
  input  logic                            AXIS_ACLK,
  input  logic                            AXIS_ARESET,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic                            S_AXIS_TLAST,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic [C_PKT_LEN_WIDTH-1:0]      pkt_len,
  output logic                            empty_pkt
);
  localparam int BYTES = C_AXIS_TDATA_WIDTH / 8;
  localparam int AW    = 2 * C_AXIS_TDATA_WIDTH;
  localparam int CW    = $clog2(2 * BYTES) + 1;
  localparam int LW    = C_PKT_LEN_WIDTH;

  if (!legal_width(C_AXIS_TDATA_WIDTH)) begin : g_bad_width
    $error("axis_keep_packer: C_AXIS_TDATA_WIDTH must be 16, 32, 64 or 128");
  end

  logic [AW-1:0]    acc, acc_nx;
  logic [CW-1:0]    cnt, cnt_nx, in_n, out_n, rem;
  pk_state_e        state;
  logic             rdy_en, last_beat, in_hs, out_hs, drop;
  logic [BYTES*8-1:0] cdata;
  logic [4:0]       cpop;
  logic [BYTES-1:0] kmask;
  logic [LW:0]      len_sum;

  axis_keep_compact #(.BYTES(BYTES)) u_compact (
    .data  (S_AXIS_TDATA),
    .keep  (S_AXIS_TKEEP),
    .cdata (cdata),
    .cnt   (cpop)
  );

  assign in_n      = CW'(cpop);
  assign last_beat = (state == PK_FLUSH) && (cnt <= CW'(BYTES));
  assign M_AXIS_TVALID = (cnt >= CW'(BYTES)) || ((state == PK_FLUSH) && (cnt != '0));
  assign out_hs    = M_AXIS_TVALID && M_AXIS_TREADY;
  // Ready may follow M_AXIS_TREADY combinationally so a full accumulator still streams at one beat/cycle.
  assign S_AXIS_TREADY = rdy_en && (state == PK_FILL) && ((cnt < CW'(BYTES)) || out_hs);
  assign in_hs     = S_AXIS_TVALID && S_AXIS_TREADY;

  assign out_n  = out_hs ? (last_beat ? cnt : CW'(BYTES)) : '0;
  assign rem    = cnt - out_n;
  assign cnt_nx = rem + (in_hs ? in_n : '0);
  assign drop   = in_hs && S_AXIS_TLAST && (cnt_nx == '0);

  // Bytes above cnt are kept zero, so shift-down plus OR-in is enough to append.
  assign acc_nx = (acc >> (out_n * 8)) | (in_hs ? (AW'(cdata) << (rem * 8)) : '0);

  assign kmask        = BYTES'(keep_mask(5'(cnt)));
  assign M_AXIS_TKEEP = !M_AXIS_TVALID ? '0 : (last_beat ? kmask : '1);
  assign M_AXIS_TLAST = M_AXIS_TVALID && last_beat;

  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    assign M_AXIS_TDATA[i*8 +: 8] = acc[i*8 +: 8] & {8{M_AXIS_TKEEP[i]}};
  end

  assign len_sum = {1'b0, pkt_len} + (LW+1)'(cpop);

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      acc       <= '0;
      cnt       <= '0;
      state     <= PK_FILL;
      rdy_en    <= 1'b0;
      pkt_len   <= '0;
      empty_pkt <= 1'b0;
    end else begin
      rdy_en    <= 1'b1;
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      empty_pkt <= drop;
      if (in_hs && S_AXIS_TLAST && !drop) state <= PK_FLUSH;
      else if (out_hs && last_beat)       state <= PK_FILL;
      if ((out_hs && last_beat) || drop) pkt_len <= '0;
      else if (in_hs)                    pkt_len <= len_sum[LW] ? '1 : len_sum[LW-1:0];
    end
  end
endmodule

// File: tb/tb_axis_keep_packer.sv
// Directed bench for axis_keep_packer: hand-computed beat tables, stall hold checks, reset mid-packet.
module tb_axis_keep_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic [3:0]  s_keep = '0;
  logic        s_last = 1'b0, s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last, m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] pkt_len;
  logic        empty_pkt;
  bit          rand_rdy = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [15:0] len;
  } beat_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    n_vec = 0, n_err = 0, n_empty = 0;

  always #5 clk = ~clk;

  axis_keep_packer dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .S_AXIS_TDATA  (s_data),
    .S_AXIS_TKEEP  (s_keep),
    .S_AXIS_TLAST  (s_last),
    .S_AXIS_TVALID (s_valid),
    .S_AXIS_TREADY (s_ready),
    .M_AXIS_TDATA  (m_data),
    .M_AXIS_TKEEP  (m_keep),
    .M_AXIS_TLAST  (m_last),
    .M_AXIS_TVALID (m_valid),
    .M_AXIS_TREADY (m_ready),
    .pkt_len       (pkt_len),
    .empty_pkt     (empty_pkt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

  // Monitor: collect output handshakes, check hold while stalled, count empty pulses.
  always begin
    beat_t b;
    bit    stalled;
    beat_t h;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) stalled = 1'b0;
      else begin
        if (stalled) begin
          chk("hold_vld",  m_valid, 1'b1);
          chk("hold_data", m_data,  h.data);
          chk("hold_keep", m_keep,  h.keep);
          chk("hold_last", m_last,  h.last);
        end
        b.data = m_data; b.keep = m_keep; b.last = m_last; b.len = pkt_len;
        if (m_valid && m_ready) begin got_q.push_back(b); stalled = 1'b0; end
        else if (m_valid)       begin h = b; stalled = 1'b1; end
        else                    stalled = 1'b0;
        if (empty_pkt) n_empty++;
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit hs;
    hs = 1'b0;
    @(negedge clk);
    s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      #1;
      if (s_ready) begin hs = 1'b1; break; end
      @(negedge clk);
    end
    if (!hs) chk("s_ready_timeout", s_ready, 1'b1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [15:0] len);
    beat_t b;
    b.data = d; b.keep = k; b.last = l; b.len = len;
    exp_q.push_back(b);
  endtask

  task automatic compare(input string tag);
    int n;
    n = exp_q.size();
    for (int t = 0; t < 600 && got_q.size() < n; t++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk({tag, "_nbeats"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
      chk($sformatf("%s_keep%0d", tag, i), got_q[i].keep, exp_q[i].keep);
      chk($sformatf("%s_last%0d", tag, i), got_q[i].last, exp_q[i].last);
      if (exp_q[i].last) chk($sformatf("%s_len", tag), got_q[i].len, exp_q[i].len);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pkt_a;
    for (int i = 0; i < 8; i++) send({4{8'(i + 1)}}, 4'hF, 1'b0);
    send(32'h0101_0101, 4'b1101, 1'b1);
  endtask

  task automatic exp_a;
    for (int i = 0; i < 8; i++) exp_beat({4{8'(i + 1)}}, 4'hF, 1'b0, 16'd0);
    exp_beat(32'h0001_0101, 4'h7, 1'b1, 16'd35);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_vld",   m_valid,   1'b0);
    chk("rst_rdy",   s_ready,   1'b0);
    chk("rst_keep",  m_keep,    4'h0);
    chk("rst_data",  m_data,    32'h0);
    chk("rst_last",  m_last,    1'b0);
    chk("rst_empty", empty_pkt, 1'b0);
    chk("rst_len",   pkt_len,   16'h0);
    rst = 1'b0;
    #1 chk("rdy_pre_edge", s_ready, 1'b0);
    @(posedge clk); #1 chk("rdy_post_edge", s_ready, 1'b1);

    // full beats + 3-byte tail
    exp_a();
    pkt_a();
    compare("a");

    // tail spilling into a 10th beat
    for (int i = 0; i < 8; i++) begin
      send({4{8'(i + 1)}}, 4'hF, 1'b0);
      exp_beat({4{8'(i + 1)}}, 4'hF, 1'b0, 16'd0);
    end
    send(32'h0C0B_0A09, 4'h7, 1'b0);
    send(32'hFFFF_0E0D, 4'h3, 1'b1);
    exp_beat(32'h0D0B_0A09, 4'hF, 1'b0, 16'd0);
    exp_beat(32'h0000_000E, 4'h1, 1'b1, 16'd37);
    compare("b");

    // sparse keeps 0..7 then full tail: 12 + 4 = 16 bytes, exactly 4 dense beats
    for (int i = 0; i < 8; i++) send(32'h0302_0100 + 32'h1010_1010 * i, 4'(i), 1'b0);
    send(32'h8382_8180, 4'hF, 1'b1);
    exp_beat(32'h3130_2110, 4'hF, 1'b0, 16'd0);
    exp_beat(32'h6152_5042, 4'hF, 1'b0, 16'd0);
    exp_beat(32'h7271_7062, 4'hF, 1'b0, 16'd0);
    exp_beat(32'h8382_8180, 4'hF, 1'b1, 16'd16);
    compare("c");

    // empty packet dropped
    n_empty = 0;
    send(32'hDEAD_BEEF, 4'h0, 1'b0);
    send(32'hDEAD_BEEF, 4'h0, 1'b0);
    send(32'hDEAD_BEEF, 4'h0, 1'b1);
    #1 chk("empty_rdy", s_ready, 1'b1);
    compare("d");
    chk("empty_pulses", n_empty, 1);
    chk("empty_len",    pkt_len, 16'h0);

    // random backpressure on the same traffic
    rand_rdy = 1'b1;
    exp_a();
    pkt_a();
    compare("e");

    // reset mid-packet discards partial data
    send(32'hA5A5_A5A5, 4'hF, 1'b0);
    send(32'h5A5A_5A5A, 4'h7, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", m_valid, 1'b0);
    chk("mid_rst_rdy", s_ready, 1'b0);
    @(negedge clk);
    rand_rdy = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rdy", s_ready, 1'b1);
    chk("post_rst_vld", m_valid, 1'b0);
    got_q.delete();
    send(32'h1234_5678, 4'b0010, 1'b1);
    exp_beat(32'h0000_0056, 4'h1, 1'b1, 16'd1);
    compare("f");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end
endmodule
